interact_regs: RTL
==================

# interact_regs

Parametrised APF bridge register bank for Pocket cores, generalising the fixed DIP/modifier/filter/status interact decoder to N 32-bit registers, per-register reset-trigger masks, write-notify pulses and a programmable core-reset pulse. Sits in the `clk_74a` domain between the APF bridge and core-side synchronisers. Optional shadow/commit mode applies multi-register updates atomically.

## Interface
- `NUM_REGS`, 8: number of user registers, 1..15.
- `ADDR_BASE`, 32'hF000_0000: control register address.
- `ADDR_STRIDE`, 32'h0100_0000: address step. Register i is at ADDR_BASE + (i+1)*ADDR_STRIDE.
- `RST_MASK`, '0 [NUM_REGS-1:0]: bit i set means a write to register i triggers a core reset.
- `RST_VALS`, '0 [NUM_REGS*32-1:0]: reset value of each register (register i = bits [32i+31:32i]).
- `RST_CYCLES`, 8000: core-reset pulse length in clk_74a cycles, ≥1.
- `clk_74a` input 1: bridge clock; the block's only clock.
- `reset` input 1: asynchronous, active-high reset.
- `bridge_addr` input 32: bridge address.
- `bridge_wr` input 1: single-cycle write strobe.
- `bridge_wr_data` input 32: write data.
- `bridge_rd` input 1: single-cycle read strobe.
- `bridge_rd_data` output 32: registered read data.
- `regs_o` output NUM_REGS*32: committed register values, flat; register i = bits [32i+31:32i].
- `reg_wr_pulse` output NUM_REGS: one-cycle pulse per committed register update.
- `reset_sw` output 1: core reset request, active-high.

## Operation
- Address decode uses exact 32-bit equality. Unmapped write: ignored. Unmapped read: returns 0.
- Control register at ADDR_BASE:
  - Write, any data: triggers a core reset.
  - Read: returns {31'b0, busy}. busy = 1 while the reset counter is nonzero.
- Register i write: value <= bridge_wr_data; reg_wr_pulse[i] = 1 for one cycle. If RST_MASK[i] is set, also triggers a core reset.
- Reset timer: a down-counter of width $clog2(RST_CYCLES+1).
  - A trigger loads RST_CYCLES.
  - Nonzero: decrement each cycle.
  - Zero: hold.
  - A retrigger mid-count reloads to RST_CYCLES, extending the pulse.
  - Multiple triggers in one cycle cause a single load.
- reset_sw = reset OR (counter != 0).
- Read and write to the same register in the same cycle: the read returns the old value.
- Asynchronous reset:
  - Registers <= RST_VALS; reg_wr_pulse = 0; bridge_rd_data = 0.
  - Counter <= RST_CYCLES, so the core stays held for RST_CYCLES cycles after reset release.
  - reset_sw = 1 while reset is asserted.

## Timing
- Write: regs_o and reg_wr_pulse update on the clock edge after bridge_wr is sampled (latency 1).
- Reset pulse: reset_sw rises one cycle after the triggering bridge_wr and stays high exactly RST_CYCLES cycles. If reset_sw is already high it stays high.
- Read: bridge_rd_data is valid one cycle after bridge_rd and holds until the next bridge_rd.
- Strobes may arrive back to back, every cycle; no stall, no backpressure.

## Configuration
- `INTERACT_SHADOW_EN` defined:
  - Writes to register i go to shadow[i] and set dirty[i]; regs_o is unchanged.
  - Commit address: ADDR_BASE + 32'h4. Any write there copies every dirty shadow into regs_o in the same cycle and clears dirty.
  - On commit, reg_wr_pulse[i] = dirty[i].
  - Reset trigger fires at commit if (dirty & RST_MASK) != 0.
  - Register reads return the shadow value; commit reads return 0.
  - A register write in the same cycle as a commit lands in the shadow only, with dirty set.
  - Async reset: shadows <= RST_VALS, dirty = 0.
- Undefined: direct writes as in Operation. ADDR_BASE+4 is unmapped. No shadow storage is synthesised.

## Structure
- `interact_pkg`:
  - CTRL_OFFSET = 0 and COMMIT_OFFSET = 4.
  - `reg_idx_t` (logic [3:0]).
  - Function `reg_addr(base, stride, i)`, used by the decode and by the bench.
- Sub-module `interact_rst_timer` (params CYCLES; ports clk_74a, reset, trigger, busy): the reload counter.

## Test plan
- Release reset, defaults (RST_CYCLES=8000) -> reset_sw high for 8000 cycles after release, then low; regs_o == RST_VALS.
- Write 32'hDEADBEEF to F200_0000, RST_MASK[1]=0 -> regs_o[63:32]=DEADBEEF next cycle; reg_wr_pulse=8'h02 for one cycle; reset_sw stays low; read back DEADBEEF one cycle after bridge_rd.
- RST_MASK[0]=1: write F100_0000, then rewrite it 100 cycles later -> reset_sw high continuously for 8100 cycles total.
- Read F000_0000 mid-pulse -> 1. Read F900_0000 with NUM_REGS=8 -> 0. Write F900_0000 -> no state change.
- INTERACT_SHADOW_EN: write regs 0 and 2, then commit F000_0004 -> regs_o unchanged until the commit cycle; then both update together with reg_wr_pulse=8'h05; reset fires iff RST_MASK&5 != 0.
- Async reset asserted mid-pulse at counter=3000 -> reset_sw=1 and registers return to RST_VALS immediately; after release, the pulse restarts at 8000.

Source files
------------

// File: rtl/interact_pkg.sv
// Shared definitions for the interact register bank: address offsets,
// register index type and the address helper used by decode and by the bench.
package interact_pkg;

    localparam logic [31:0] CTRL_OFFSET   = 32'h0000_0000;
    localparam logic [31:0] COMMIT_OFFSET = 32'h0000_0004;

    typedef logic [3:0] reg_idx_t;

    // Register i lives one stride above the previous one, starting one stride above the base.
    function automatic logic [31:0] reg_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input reg_idx_t    idx);
        return base + ({28'd0, idx} + 32'd1) * stride;
    endfunction

endpackage

// File: rtl/interact_rst_timer.sv
// Reloadable core-reset down-counter: a trigger loads CYCLES, a retrigger
// extends the pulse, and busy stays high until the count reaches zero.
module interact_rst_timer #(
    parameter int CYCLES = 8000
) (
    input  logic clk_74a,
    input  logic reset,
    input  logic trigger,
    output logic busy
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(CYCLES);

    logic [CW-1:0] count;

    // Loading on reset keeps the core held for a full pulse after release.
    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            count <= LOAD;
        end else if (trigger) begin
            count <= LOAD;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/interact_regs.sv
// APF bridge register bank with per-register reset triggers and write pulses.
// Build option INTERACT_SHADOW_EN: writes stage in shadow registers until a commit write.
module interact_regs
    import interact_pkg::*;
#(
    parameter int                     NUM_REGS    = 8,
    parameter logic [31:0]            ADDR_BASE   = 32'hF000_0000,
    parameter logic [31:0]            ADDR_STRIDE = 32'h0100_0000,
    parameter logic [NUM_REGS-1:0]    RST_MASK    = '0,
    parameter logic [NUM_REGS*32-1:0] RST_VALS    = '0,
    parameter int                     RST_CYCLES  = 8000
) (
    input  logic                     clk_74a,
    input  logic                     reset,
    input  logic [31:0]              bridge_addr,
    input  logic                     bridge_wr,
    input  logic [31:0]              bridge_wr_data,
    input  logic                     bridge_rd,
    output logic [31:0]              bridge_rd_data,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      reg_wr_pulse,
    output logic                     reset_sw
);

    logic [NUM_REGS-1:0] hit;
    logic                ctrl_hit;
    logic                trigger;
    logic                busy;
    logic [31:0]         regs   [NUM_REGS];
    logic [31:0]         rd_src [NUM_REGS];
    logic [31:0]         rd_mux;

    assign ctrl_hit = (bridge_addr == ADDR_BASE + CTRL_OFFSET);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            hit[i] = (bridge_addr == reg_addr(ADDR_BASE, ADDR_STRIDE, reg_idx_t'(i)));
        end
    end

`ifdef INTERACT_SHADOW_EN
    logic [31:0]         shadow [NUM_REGS];
    logic [NUM_REGS-1:0] dirty;
    logic                commit_hit;
    logic                commit;

    assign commit_hit = (bridge_addr == ADDR_BASE + COMMIT_OFFSET);
    assign commit     = bridge_wr && commit_hit;
    assign trigger    = bridge_wr && (ctrl_hit || (commit_hit && ((dirty & RST_MASK) != '0)));

    // Commit copies the pre-write shadow; a write landing alongside stays staged and dirty.
    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i]   <= RST_VALS[32*i +: 32];
                shadow[i] <= RST_VALS[32*i +: 32];
            end
            dirty        <= '0;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= commit ? dirty : '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit && dirty[i]) begin
                    regs[i] <= shadow[i];
                end
                if (bridge_wr && hit[i]) begin
                    shadow[i] <= bridge_wr_data;
                end
            end
            dirty <= (commit ? '0 : dirty) | (bridge_wr ? hit : '0);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_src[i] = shadow[i];
        end
    end
`else
    assign trigger = bridge_wr && (ctrl_hit || ((hit & RST_MASK) != '0));

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RST_VALS[32*i +: 32];
            end
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= bridge_wr ? hit : '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bridge_wr && hit[i]) begin
                    regs[i] <= bridge_wr_data;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_src[i] = regs[i];
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        if (ctrl_hit) begin
            rd_mux = {31'b0, busy};
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hit[i]) begin
                rd_mux = rd_src[i];
            end
        end
    end

    // Read data is captured from pre-edge state, so a same-cycle write reads back the old value.
    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            bridge_rd_data <= '0;
        end else if (bridge_rd) begin
            bridge_rd_data <= rd_mux;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[32*g +: 32] = regs[g];
    end

    interact_rst_timer #(
        .CYCLES (RST_CYCLES)
    ) u_rst_timer (
        .clk_74a (clk_74a),
        .reset   (reset),
        .trigger (trigger),
        .busy    (busy)
    );

    assign reset_sw = reset | busy;

endmodule
